// File: rtl/scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// scan_decoder_pkg
//
// Shared definitions for the scan decoder slice:
//   - scan_state_t : sequencer states (IDLE / HOLD / SCAN)
//   - clog2        : ceiling log2 constant function
//   - count_width  : prescale counter width, never narrower than one bit
//
// No ports; imported by the interface, the decoder and the top.
// ----------------------------------------------------------------------------
package scan_decoder_pkg;

    // Encodings are fixed so the state register reads the same in every
    // lab that reuses this decoder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } scan_state_t;

    // Ceiling log2: clog2(1) = 0, clog2(3) = 2, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A prescale of 1 still needs a one-bit counter so the terminal-count
    // compare has something to look at.
    function automatic int count_width(input int prescale);
        int w;
        w = clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_if.sv
// ----------------------------------------------------------------------------
// scan_decoder_if
//
// Control and result bundle of the scan decoder.
//   Parameter N : select width; one-hot output width is 2**N.
//
//   en    : 1 = outputs active, 0 = outputs blanked
//   mode  : 0 = direct (hold loaded index), 1 = scan
//   load  : one-cycle strobe, capture sel into the index register
//   sel   : index to load
//   y     : registered one-hot, y[0] is the leftmost bit
//   idx   : current index register
//   wrap  : one-cycle pulse when a scan advance rolls idx over to 0
//
// master drives the controls (test bench / parent block), slave is the
// decoder itself.
// ----------------------------------------------------------------------------
interface scan_decoder_if #(
    parameter int N = 2
);

    logic                  en;
    logic                  mode;
    logic                  load;
    logic [N-1:0]          sel;
    logic [0:(1 << N) - 1] y;
    logic [N-1:0]          idx;
    logic                  wrap;

    modport master (
        output en,
        output mode,
        output load,
        output sel,
        input  y,
        input  idx,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  load,
        input  sel,
        output y,
        output idx,
        output wrap
    );

endinterface : scan_decoder_if

// File: rtl/scan_decoder_onehot_dec.sv
// ----------------------------------------------------------------------------
// onehot_dec
//
// Purely combinational N-to-2**N one-hot decoder; the generalised form of
// the fixed 2-to-4 lab decoder.
//   Parameter N : select width
//   idx    (in)  : N-bit index
//   onehot (out) : [0:2**N-1], onehot[k] = 1 when idx == k
//
// Bit 0 is the leftmost bit so idx 0 reads as 1000 for N = 2, matching the
// original decoder's truth table.
// ----------------------------------------------------------------------------
module onehot_dec #(
    parameter int N = 2
) (
    input  logic [N-1:0]          idx,
    output logic [0:(1 << N) - 1] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// ----------------------------------------------------------------------------
// scan_decoder
//
// Registered N-to-2**N one-hot decoder with a built-in scan sequencer.
//   Parameter N        : select width (1..5), output width 2**N
//   Parameter PRESCALE : clock cycles per scan step (>= 1)
//
//   clk  (in) : rising-edge clock
//   rst  (in) : asynchronous, active-high reset
//   bus  (slave modport of scan_decoder_if):
//       en, mode, load, sel in; y, idx, wrap out (all outputs registered)
//
// Behaviour summary:
//   en = 0          -> IDLE, y blanked, idx retained, load ignored
//   en = 1, mode 0  -> HOLD, y = onehot(idx), load captures sel
//   en = 1, mode 1  -> SCAN, idx advances every PRESCALE cycles, wrap pulses
//                      on the rollover to 0; load resynchronises the scan
// ----------------------------------------------------------------------------
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N        = 2,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);

    localparam int               OUT_W    = 1 << N;
    localparam int               CNT_W    = count_width(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(PRESCALE - 1);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [N-1:0]     idx_q;
    logic [N-1:0]     idx_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [0:OUT_W-1] y_q;
    logic [0:OUT_W-1] y_d;
    logic [0:OUT_W-1] dec_out;
    logic             wrap_q;
    logic             wrap_d;

    // The decoder looks at the next index so y lands in the same edge as
    // idx, keeping every output a plain register.
    onehot_dec #(
        .N (N)
    ) u_onehot_dec (
        .idx    (idx_d),
        .onehot (dec_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    // The prescale count only survives while staying in SCAN without a
    // load; every other path clears it, which covers scan entry, scan exit
    // and resync with one default.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = '0;
        wrap_d  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
        end else if (!bus.mode) begin
            state_d = HOLD;
            if (bus.load) begin
                idx_d = bus.sel;
            end
        end else begin
            state_d = SCAN;
            if (bus.load) begin
                // Resync beats a coincident terminal count: no step, no wrap.
                idx_d = bus.sel;
            end else if (state_q != SCAN) begin
                // Entry edge starts the count at 0 so the first step comes
                // a full PRESCALE cycles later.
                idx_d = idx_q;
            end else if (count_q == CNT_TERM) begin
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == '1);
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        y_d = (state_d == IDLE) ? '0 : dec_out;
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule : scan_decoder
